// File: rtl/alu_writeback.sv
// Write-back stage behind the ALU: captures a result and writes it into the
// 8-bit register file one byte per cycle. It also keeps zero/overflow flags for branches.
module alu_writeback #(
  parameter int REG_AW = 3,
  parameter int RSLT_W = 16
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RSLT_W-1:0] in_rslt,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_dst,
  input  logic              in_wide,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [7:0]        rf_wdata,
  output logic              flag_z,
  output logic              flag_ov,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [RSLT_W-1:0]   rslt_q, rslt_d;
  logic [REG_AW-1:0]   dst_q, dst_d;
  logic                wide_q, wide_d;
  logic [2:0]          op_q, op_d;
  logic                flag_z_q, flag_z_d;
  logic                flag_ov_q, flag_ov_d;
  logic                rf_we_q, rf_we_d;
  logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [7:0]          rf_wdata_q, rf_wdata_d;
  logic                accept;

  // in_ready depends only on state so issue logic never sees a combinational loop.
  assign in_ready = (state_q != WR_LO) || !wide_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    rslt_d     = rslt_q;
    dst_d      = dst_q;
    wide_d     = wide_q;
    op_d       = op_q;
    flag_z_d   = flag_z_q;
    flag_ov_d  = flag_ov_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;

    unique case (state_q)
      IDLE:    state_d = accept ? WR_LO : IDLE;
      WR_LO:   state_d = wide_q ? WR_HI : (accept ? WR_LO : IDLE);
      WR_HI:   state_d = accept ? WR_LO : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      rslt_d    = in_rslt;
      dst_d     = in_dst;
      wide_d    = in_wide;
      op_d      = in_op;
      flag_z_d  = (in_rslt == '0);
      flag_ov_d = |in_rslt[RSLT_W-1:8];
    end

    // Outputs are registered: they describe the write performed in the next state.
    if (state_d == WR_LO) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = dst_d;
      rf_wdata_d = rslt_d[7:0];
    end else if (state_d == WR_HI) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = dst_q + REG_AW'(1);
      rf_wdata_d = rslt_q[RSLT_W-1:8];
    end
  end

  // NOTE: the async reset clears the holding regs too, because flags must read 0 right after reset.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rslt_q     <= '0;
      dst_q      <= '0;
      wide_q     <= 1'b0;
      op_q       <= '0;
      flag_z_q   <= 1'b0;
      flag_ov_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      rslt_q     <= rslt_d;
      dst_q      <= dst_d;
      wide_q     <= wide_d;
      op_q       <= op_d;
      flag_z_q   <= flag_z_d;
      flag_ov_q  <= flag_ov_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign flag_z   = flag_z_q;
  assign flag_ov  = flag_ov_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback. It drives hand-computed vectors and
// checks the register-file writes, the flags and the handshake.
module tb_alu_writeback;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_rslt;
  logic [2:0]  in_op;
  logic [2:0]  in_dst;
  logic        in_wide;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic        flag_z;
  logic        flag_ov;
  logic        busy;

  int checks = 0;
  int passes = 0;

  alu_writeback #(.REG_AW(3), .RSLT_W(16)) dut (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rslt  (in_rslt),
    .in_op    (in_op),
    .in_dst   (in_dst),
    .in_wide  (in_wide),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .flag_z   (flag_z),
    .flag_ov  (flag_ov),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic [2:0] d, input logic w);
    in_valid = v;
    in_rslt  = r;
    in_dst   = d;
    in_wide  = w;
    in_op    = 3'd5;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [2:0] a, input logic [7:0] d);
    check({tag, "_we"},   32'(rf_we),    32'(we));
    check({tag, "_addr"}, 32'(rf_waddr), 32'(a));
    check({tag, "_data"}, 32'(rf_wdata), 32'(d));
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 16'h0, 3'd0, 1'b0);
    #12;
    chk_wr("reset", 1'b0, 3'd0, 8'h00);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_z", 32'(flag_z), 32'd0);
    check("reset_ov", 32'(flag_ov), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    reset_n = 1'b1;

    // 1: narrow write
    @(negedge CLK);
    drive(1'b1, 16'h00A5, 3'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    chk_wr("t1_lo", 1'b1, 3'd2, 8'hA5);
    check("t1_z", 32'(flag_z), 32'd0);
    check("t1_ov", 32'(flag_ov), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready", 32'(in_ready), 32'd1);
    tick();
    chk_wr("t1_idle", 1'b0, 3'd0, 8'h00);
    check("t1_busy_idle", 32'(busy), 32'd0);

    // 2: wide write wrapping r7 -> r0
    drive(1'b1, 16'h1FE0, 3'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_wr("t2_lo", 1'b1, 3'd7, 8'hE0);
    check("t2_ready_lo", 32'(in_ready), 32'd0);
    check("t2_ov", 32'(flag_ov), 32'd1);
    check("t2_z", 32'(flag_z), 32'd0);
    tick();
    chk_wr("t2_hi", 1'b1, 3'd0, 8'h1F);
    check("t2_ready_hi", 32'(in_ready), 32'd1);
    tick();
    chk_wr("t2_idle", 1'b0, 3'd0, 8'h00);

    // 3: streaming narrow results, one per cycle
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'(i + 1), 3'(i), 1'b0);
      check($sformatf("t3_ready%0d", i), 32'(in_ready), 32'd1);
      tick();
      chk_wr($sformatf("t3_wr%0d", i), 1'b1, 3'(i), 8'(i + 1));
    end
    in_valid = 1'b0;
    tick();
    chk_wr("t3_idle", 1'b0, 3'd0, 8'h00);

    // 4: wide result, then a held valid accepted in the WR_HI cycle
    drive(1'b1, 16'h1234, 3'd3, 1'b1);
    tick();
    chk_wr("t4_lo", 1'b1, 3'd3, 8'h34);
    check("t4_ready_lo", 32'(in_ready), 32'd0);
    drive(1'b1, 16'h0056, 3'd5, 1'b0);
    tick();
    chk_wr("t4_hi", 1'b1, 3'd4, 8'h12);
    check("t4_ready_hi", 32'(in_ready), 32'd1);
    check("t4_ov_first", 32'(flag_ov), 32'd1);
    tick();
    in_valid = 1'b0;
    chk_wr("t4_next", 1'b1, 3'd5, 8'h56);
    check("t4_ov_second", 32'(flag_ov), 32'd0);
    tick();
    chk_wr("t4_idle", 1'b0, 3'd0, 8'h00);

    // 5: zero and overflow flags
    drive(1'b1, 16'h0000, 3'd1, 1'b0);
    tick();
    chk_wr("t5_zero", 1'b1, 3'd1, 8'h00);
    check("t5_z1", 32'(flag_z), 32'd1);
    check("t5_ov0", 32'(flag_ov), 32'd0);
    drive(1'b1, 16'h0100, 3'd6, 1'b0);
    tick();
    in_valid = 1'b0;
    chk_wr("t5_ovf", 1'b1, 3'd6, 8'h00);
    check("t5_z0", 32'(flag_z), 32'd0);
    check("t5_ov1", 32'(flag_ov), 32'd1);
    tick();
    check("t5_hold_z", 32'(flag_z), 32'd0);
    check("t5_hold_ov", 32'(flag_ov), 32'd1);

    // 6: async reset during WR_LO of a wide result
    drive(1'b1, 16'hABCD, 3'd2, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_wr("t6_lo", 1'b1, 3'd2, 8'hCD);
    #2;
    reset_n = 1'b0;
    #1;
    chk_wr("t6_rst", 1'b0, 3'd0, 8'h00);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_z", 32'(flag_z), 32'd0);
    check("t6_ov", 32'(flag_ov), 32'd0);
    @(negedge CLK);
    reset_n = 1'b1;
    tick();
    chk_wr("t6_after1", 1'b0, 3'd0, 8'h00);
    tick();
    chk_wr("t6_after2", 1'b0, 3'd0, 8'h00);
    check("t6_busy_after", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
